ooo_flush_ctrl: RTL and testbench

Parametrised stall/flush controller for the out-of-order core, generalising hazard control to `NUM_FU` functional units. It adds a sequenced recovery state machine that drives multi-cycle pipeline flushes, cache fence handshakes and a single-cycle PC redirect. It sits between the commit stage (event source) and fetch/decode/execute (stall and flush sinks).

---
 rtl/rv32i_types_pkg.sv | 27 ++
 rtl/recov_event_prio.sv | 29 ++
 rtl/ooo_flush_ctrl.sv | 140 ++++++++++++++
 tb/tb_ooo_flush_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared types for the out-of-order core recovery/hazard control.
// Holds the recovery FSM states, the recovery cause encoding and counter width.
package rv32i_types_pkg;

  typedef enum logic [2:0] {
    RUN,
    FLUSH,
    FENCE_D,
    FENCE_I,
    REDIRECT
  } flush_state_t;

  typedef enum logic [1:0] {
    INTR,
    EXC,
    IFENCE,
    MISPRED
  } recov_cause_t;

  localparam int FLUSH_CNT_W = 4;

  // Traps (interrupt/exception) redirect through the privileged vector.
  function automatic logic cause_is_trap(input recov_cause_t cause);
    return (cause == INTR) || (cause == EXC);
  endfunction

endpackage

// File: rtl/recov_event_prio.sv
// Fixed-priority selection among commit recovery events: intr > exc > ifence > mispredict.
module recov_event_prio
  import rv32i_types_pkg::*;
(
  input  logic         intr_valid,
  input  logic         exc_valid,
  input  logic         ifence_valid,
  input  logic         mispredict_valid,
  output logic         ev_valid,
  output recov_cause_t ev_cause
);

  always_comb begin
    ev_valid = 1'b1;
    ev_cause = MISPRED;
    if (intr_valid) begin
      ev_cause = INTR;
    end else if (exc_valid) begin
      ev_cause = EXC;
    end else if (ifence_valid) begin
      ev_cause = IFENCE;
    end else if (mispredict_valid) begin
      ev_cause = MISPRED;
    end else begin
      ev_valid = 1'b0;
    end
  end

endmodule

// File: rtl/ooo_flush_ctrl.sv
// Stall/flush controller: combinational hazard stalls in RUN plus a sequenced
// recovery machine (flush -> optional cache fences -> single-cycle PC redirect).
module ooo_flush_ctrl
  import rv32i_types_pkg::*;
#(
  parameter int NUM_FU       = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [NUM_FU-1:0] fu_busy,
  input  logic              issue_valid,
  input  logic [NUM_FU-1:0] issue_fu,
  input  logic              rob_full,
  input  logic              data_hazard,
  input  logic              i_mem_busy,
  input  logic              intr_valid,
  input  logic              exc_valid,
  input  logic              ifence_valid,
  input  logic              mispredict_valid,
  input  logic [31:0]       priv_pc,
  input  logic [31:0]       brj_addr,
  input  logic [31:0]       ifence_pc,
  input  logic              dflushed,
  input  logic              iflushed,
  output logic [NUM_FU-1:0] stall_fu,
  output logic              stall_de,
  output logic              pc_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_comm_flush,
  output logic              npc_sel,
  output logic [31:0]       redirect_pc,
  output logic              insert_priv_pc,
  output logic              dflush_req,
  output logic              iflush_req
);

  localparam logic [FLUSH_CNT_W-1:0] CNT_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  flush_state_t           state, state_n;
  logic [FLUSH_CNT_W-1:0] cnt;
  logic                   trap_q;
  logic                   fence_q;
  logic                   ev_valid;
  recov_cause_t           ev_cause;
  logic                   run_stall;

  recov_event_prio u_prio (
    .intr_valid       (intr_valid),
    .exc_valid        (exc_valid),
    .ifence_valid     (ifence_valid),
    .mispredict_valid (mispredict_valid),
    .ev_valid         (ev_valid),
    .ev_cause         (ev_cause)
  );

  assign run_stall = rob_full | data_hazard | (issue_valid & (|(issue_fu & fu_busy)));

  // Capture the winning event only while running; later events are dropped.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= RUN;
      cnt         <= '0;
      redirect_pc <= '0;
      trap_q      <= 1'b0;
      fence_q     <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        RUN: begin
          if (ev_valid) begin
            cnt     <= CNT_INIT;
            trap_q  <= cause_is_trap(ev_cause);
            fence_q <= (ev_cause == IFENCE);
            case (ev_cause)
              INTR, EXC: redirect_pc <= priv_pc;
              IFENCE:    redirect_pc <= ifence_pc;
              default:   redirect_pc <= brj_addr;
            endcase
          end
        end
        FLUSH: begin
          if (cnt != '0) cnt <= cnt - FLUSH_CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n        = state;
    stall_fu       = fu_busy;
    stall_de       = run_stall;
    pc_en          = ~(run_stall | i_mem_busy);
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_comm_flush  = 1'b0;
    npc_sel        = 1'b0;
    insert_priv_pc = 1'b0;
    dflush_req     = 1'b0;
    iflush_req     = 1'b0;
    case (state)
      RUN: begin
        if (ev_valid) state_n = FLUSH;
      end
      FLUSH: begin
        stall_fu      = {NUM_FU{1'b1}};
        stall_de      = 1'b1;
        pc_en         = 1'b0;
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
        ex_comm_flush = 1'b1;
        if (cnt == '0) state_n = fence_q ? FENCE_D : REDIRECT;
      end
      FENCE_D: begin
        stall_fu   = {NUM_FU{1'b1}};
        stall_de   = 1'b1;
        pc_en      = 1'b0;
        dflush_req = 1'b1;
        if (dflushed) state_n = FENCE_I;
      end
      FENCE_I: begin
        stall_fu   = {NUM_FU{1'b1}};
        stall_de   = 1'b1;
        pc_en      = 1'b0;
        iflush_req = 1'b1;
        if (iflushed) state_n = REDIRECT;
      end
      REDIRECT: begin
        npc_sel        = 1'b1;
        pc_en          = 1'b1;
        insert_priv_pc = trap_q;
        state_n        = RUN;
      end
      default: state_n = RUN;
    endcase
  end

endmodule

// File: tb/tb_ooo_flush_ctrl.sv
// Randomized scoreboard bench for ooo_flush_ctrl: expected redirects are queued
// at event issue and matched by a monitor against each observed npc_sel pulse.
module tb_ooo_flush_ctrl;

  localparam int NF = 4;
  localparam int FC = 2;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [NF-1:0] fu_busy, issue_fu, stall_fu;
  logic          issue_valid, rob_full, data_hazard, i_mem_busy;
  logic          intr_valid, exc_valid, ifence_valid, mispredict_valid;
  logic [31:0]   priv_pc, brj_addr, ifence_pc, redirect_pc;
  logic          dflushed, iflushed;
  logic          stall_de, pc_en, if_id_flush, id_ex_flush, ex_comm_flush;
  logic          npc_sel, insert_priv_pc, dflush_req, iflush_req;

  ooo_flush_ctrl #(.NUM_FU(NF), .FLUSH_CYCLES(FC)) dut (
    .CLK(CLK), .nRST(nRST), .fu_busy(fu_busy), .issue_valid(issue_valid),
    .issue_fu(issue_fu), .rob_full(rob_full), .data_hazard(data_hazard),
    .i_mem_busy(i_mem_busy), .intr_valid(intr_valid), .exc_valid(exc_valid),
    .ifence_valid(ifence_valid), .mispredict_valid(mispredict_valid),
    .priv_pc(priv_pc), .brj_addr(brj_addr), .ifence_pc(ifence_pc),
    .dflushed(dflushed), .iflushed(iflushed), .stall_fu(stall_fu),
    .stall_de(stall_de), .pc_en(pc_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_comm_flush(ex_comm_flush),
    .npc_sel(npc_sel), .redirect_pc(redirect_pc),
    .insert_priv_pc(insert_priv_pc), .dflush_req(dflush_req),
    .iflush_req(iflush_req)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    int          trap;
    int          flen;
    int          dlen;
    int          ilen;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   dwait_cur = 1;
  int   iwait_cur = 1;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
  endtask

  // Monitor: measures each recovery sequence and matches it on the redirect pulse.
  initial begin : monitor
    int flen_all, flen_any, dlen, ilen;
    exp_t e;
    flen_all = 0; flen_any = 0; dlen = 0; ilen = 0;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        flen_all = 0; flen_any = 0; dlen = 0; ilen = 0;
      end else if (npc_sel) begin
        if (sb.size() == 0) begin
          chk("spurious_redirect", 32'(npc_sel), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("redirect_pc", redirect_pc, e.pc);
          chk("insert_priv_pc", 32'(insert_priv_pc), 32'(e.trap));
          chk("flush_len_all", 32'(flen_all), 32'(e.flen));
          chk("flush_len_any", 32'(flen_any), 32'(e.flen));
          chk("dflush_len", 32'(dlen), 32'(e.dlen));
          chk("iflush_len", 32'(ilen), 32'(e.ilen));
          chk("redirect_cycle", 32'(cyc), 32'(e.at));
          chk("redirect_pc_en", 32'(pc_en), 32'd1);
          chk("redirect_noflush", 32'(if_id_flush | id_ex_flush | ex_comm_flush), 32'd0);
        end
        flen_all = 0; flen_any = 0; dlen = 0; ilen = 0;
      end else begin
        if (if_id_flush && id_ex_flush && ex_comm_flush) flen_all++;
        if (if_id_flush || id_ex_flush || ex_comm_flush) flen_any++;
        if (dflush_req) dlen++;
        if (iflush_req) ilen++;
      end
    end
  end

  // Cache model: acknowledges a request after it has been up for the chosen number of cycles.
  initial begin : cache_resp
    int dcnt, icnt;
    dcnt = 0; icnt = 0;
    dflushed = 1'b0; iflushed = 1'b0;
    forever begin
      @(negedge CLK);
      if (dflush_req) begin dcnt++; dflushed = (dcnt >= dwait_cur); end
      else begin dcnt = 0; dflushed = 1'b0; end
      if (iflush_req) begin icnt++; iflushed = (icnt >= iwait_cur); end
      else begin icnt = 0; iflushed = 1'b0; end
    end
  end

  task automatic set_idle();
    fu_busy = '0; issue_valid = 0; issue_fu = '0; rob_full = 0; data_hazard = 0;
    i_mem_busy = 0; intr_valid = 0; exc_valid = 0; ifence_valid = 0;
    mispredict_valid = 0;
  endtask

  task automatic run_check(input logic [NF-1:0] fb, input logic iv, input logic [NF-1:0] ifu,
                           input logic rf, input logic dh, input logic imb);
    logic exp_de;
    fu_busy = fb; issue_valid = iv; issue_fu = ifu; rob_full = rf; data_hazard = dh;
    i_mem_busy = imb;
    exp_de = rf || dh || (iv && ((ifu & fb) != '0));
    @(negedge CLK);
    chk("run_stall_fu", 32'(stall_fu), 32'(fb));
    chk("run_stall_de", 32'(stall_de), 32'(exp_de));
    chk("run_pc_en", 32'(pc_en), 32'(!(exp_de || imb)));
    chk("run_noflush", 32'(if_id_flush | npc_sel | dflush_req | iflush_req), 32'd0);
    @(posedge CLK); #1;
  endtask

  // Issue one cycle of recovery events; the queued expectation follows the priority rules.
  task automatic do_event(input logic iv, input logic ev, input logic fv, input logic mv,
                          input logic [31:0] ppc, input logic [31:0] bpc,
                          input logic [31:0] fpc, input int dw, input int iw);
    exp_t e;
    dwait_cur = dw; iwait_cur = iw;
    intr_valid = iv; exc_valid = ev; ifence_valid = fv; mispredict_valid = mv;
    priv_pc = ppc; brj_addr = bpc; ifence_pc = fpc;
    @(posedge CLK); #1;
    e.flen = FC; e.dlen = 0; e.ilen = 0;
    if (iv || ev) begin e.pc = ppc; e.trap = 1; end
    else if (fv) begin e.pc = fpc; e.trap = 0; e.dlen = dw; e.ilen = iw; end
    else begin e.pc = bpc; e.trap = 0; end
    e.at = cyc + FC + e.dlen + e.ilen;
    sb.push_back(e);
    intr_valid = 0; exc_valid = 0; ifence_valid = 0; mispredict_valid = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge CLK);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    set_idle();
    priv_pc = '0; brj_addr = '0; ifence_pc = '0;
    nRST = 0;
    fu_busy = 4'b1010;
    #2;
    chk("rst_pc_en", 32'(pc_en), 32'd1);
    chk("rst_stall_de", 32'(stall_de), 32'd0);
    chk("rst_stall_fu", 32'(stall_fu), 32'(4'b1010));
    chk("rst_outs", 32'({if_id_flush, id_ex_flush, ex_comm_flush, npc_sel,
                         insert_priv_pc, dflush_req, iflush_req}), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    @(posedge CLK); #1;
    nRST = 1;
    @(posedge CLK); #1;

    run_check(4'b0100, 1, 4'b0100, 0, 0, 0);
    run_check(4'b0100, 1, 4'b0001, 0, 0, 0);
    run_check(4'b0000, 0, 4'b0000, 1, 0, 0);
    run_check(4'b0000, 0, 4'b0000, 0, 1, 0);
    run_check(4'b1111, 0, 4'b1000, 0, 0, 1);
    set_idle();

    do_event(0, 0, 0, 1, 32'h0, 32'h0000_1040, 32'h0, 1, 1);
    wait_done();
    run_check(4'b0000, 0, 4'b0000, 0, 0, 0);

    do_event(1, 1, 0, 1, 32'h8000_0004, 32'h0000_2000, 32'h0, 1, 1);
    wait_done();
    repeat (5) @(posedge CLK);
    #1;

    do_event(0, 0, 1, 0, 32'h0, 32'h0, 32'h0000_0200, 5, 3);
    wait_done();

    do_event(0, 0, 0, 1, 32'h0, 32'h0000_3000, 32'h0, 1, 1);
    mispredict_valid = 1; brj_addr = 32'h0000_4444;
    @(posedge CLK); #1;
    mispredict_valid = 0;
    wait_done();
    repeat (8) @(posedge CLK);
    #1;

    // Reset in the middle of the data-cache fence.
    do_event(0, 0, 1, 0, 32'h0, 32'h0, 32'h0000_0abc, 20, 2);
    for (int i = 0; i < 20 && !dflush_req; i++) @(negedge CLK);
    chk("fence_d_reached", 32'(dflush_req), 32'd1);
    @(posedge CLK); #1;
    nRST = 0;
    #1;
    chk("rst_async_dflush", 32'(dflush_req), 32'd0);
    chk("rst_async_pc_en", 32'(pc_en), 32'd1);
    sb.delete();
    @(posedge CLK); #1;
    nRST = 1;
    @(negedge CLK);
    chk("post_rst_redirect_pc", redirect_pc, 32'd0);
    chk("post_rst_run", 32'({if_id_flush, npc_sel, dflush_req, iflush_req, stall_de}), 32'd0);
    @(posedge CLK); #1;

    for (int n = 0; n < 14; n++) begin
      logic [3:0] evs;
      evs = 4'($urandom_range(1, 15));
      do_event(evs[3], evs[2], evs[1], evs[0], $urandom, $urandom, $urandom,
               $urandom_range(1, 6), $urandom_range(1, 6));
      wait_done();
      for (int k = 0; k < 3; k++)
        run_check(4'($urandom), 1'($urandom), 4'(4'b0001 << $urandom_range(0, 3)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 3) == 0));
      set_idle();
    end

    repeat (5) @(posedge CLK);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
